// File: rtl/mips_load_store_controller_if.sv
// Pipeline request/response and data-memory handshake bundle for the load/store controller.
// The slave modport is the controller's view; master is the surrounding pipeline plus memory.
interface mips_load_store_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid,
    output req_opcode,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

  modport slave (
    input  req_valid,
    input  req_opcode,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );
endinterface

// File: rtl/mips_load_store_controller.sv
// Memory-stage load/store sequencer: aligned word accesses, read-modify-write for sb/sh,
// lane-selected and extended load data, error response on misalignment/bad opcode/timeout.
module mips_load_store_controller #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_load_store_controller_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [CntW-1:0]   wait_inc;
  logic              req_legal;
  logic [4:0]        byte_sh;
  logic [4:0]        half_sh;
  logic [31:0]       rd_byte_aligned;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign wait_inc        = wait_q + 1'b1;
  assign byte_sh         = {addr_q[1:0], 3'b000};
  assign half_sh         = {addr_q[1], 4'b0000};
  assign rd_byte_aligned = bus.mem_rdata >> byte_sh;
  assign rd_half         = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  // Opcode support and natural alignment of the incoming request.
  always_comb begin
    req_legal = 1'b0;
    unique case (bus.req_opcode)
      OpLw, OpSw:        req_legal = (bus.req_addr[1:0] == 2'b00);
      OpLh, OpLhu, OpSh: req_legal = ~bus.req_addr[0];
      OpLb, OpLbu, OpSb: req_legal = 1'b1;
      default:           req_legal = 1'b0;
    endcase
  end

  always_comb begin
    load_data = '0;
    unique case (op_q)
      OpLw:    load_data = bus.mem_rdata;
      OpLh:    load_data = {{16{rd_half[15]}}, rd_half};
      OpLhu:   load_data = {16'h0000, rd_half};
      OpLb:    load_data = {{24{rd_byte_aligned[7]}}, rd_byte_aligned[7:0]};
      OpLbu:   load_data = {24'h000000, rd_byte_aligned[7:0]};
      default: load_data = '0;
    endcase
  end

  // Replace only the addressed lane of the word just read.
  always_comb begin
    if (op_q == OpSh) begin
      merged_word = (bus.mem_rdata & ~(32'h0000_FFFF << half_sh)) |
                    ({16'h0000, wdata_q} << half_sh);
    end else begin
      merged_word = (bus.mem_rdata & ~(32'h0000_00FF << byte_sh)) |
                    ({24'h000000, wdata_q[7:0]} << byte_sh);
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_wdata_d = mem_wdata_q;
    wait_d      = wait_q;
    err_d       = 1'b0;
    rdata_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d    = bus.req_opcode;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata[15:0];
          wait_d  = '0;
          if (!req_legal) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else if (bus.req_opcode == OpSw) begin
            state_d     = StWrite;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d = StRead;
          end
        end
      end

      StRead: begin
        if (bus.mem_ack) begin
          wait_d = '0;
          if (op_q == OpSb || op_q == OpSh) begin
            state_d     = StWrite;
            mem_wdata_d = merged_word;
          end else begin
            state_d = StResp;
            rdata_d = load_data;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == CntW'(MAX_WAIT)) begin
            state_d = StResp;
            err_d   = 1'b1;
          end
        end
      end

      StWrite: begin
        if (bus.mem_ack) begin
          wait_d  = '0;
          state_d = StResp;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == CntW'(MAX_WAIT)) begin
            state_d = StResp;
            err_d   = 1'b1;
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_req    = (state_q == StRead) || (state_q == StWrite);
  assign bus.mem_we     = (state_q == StWrite);
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mips_load_store_controller.sv
// Scoreboard bench for mips_load_store_controller: memory responder with programmable waits,
// expected responses and writes queued at stimulus time and checked as the DUT produces them.
module tb_mips_load_store_controller;

  localparam int unsigned MaxWait = 4;

  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          req_cyc;
    int          we_cyc;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  resp_t       exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int mem_waits = 0;
  bit never_ack = 1'b0;

  mips_load_store_controller_if bus ();

  mips_load_store_controller #(
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: acks after mem_waits wait cycles, checks each write against the queue.
  initial begin
    int wcnt;
    wr_t w;
    wcnt          = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !never_ack && wcnt >= mem_waits) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          if (wr_q.size() == 0) begin
            check_eq("wr_unexpected", 32'h1, 32'h0);
          end else begin
            w = wr_q.pop_front();
            check_eq("wr_addr", bus.mem_addr, w.addr);
            check_eq("wr_data", bus.mem_wdata, w.data);
          end
          mem_model[bus.mem_addr] = bus.mem_wdata;
        end else begin
          bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'h0;
        end
        wcnt = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hA5A5_A5A5;
        wcnt          = bus.mem_req ? wcnt + 1 : 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on resp_valid, checks handshake stability.
  initial begin
    int          req_cnt;
    int          we_cnt;
    logic        prev_req;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wd;
    resp_t       e;
    req_cnt  = 0;
    we_cnt   = 0;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        req_cnt  = 0;
        we_cnt   = 0;
        prev_req = 1'b0;
      end else begin
        if (bus.mem_req) begin
          req_cnt++;
          if (bus.mem_we) we_cnt++;
          check_eq("addr_align", {30'h0, bus.mem_addr[1:0]}, 32'h0);
          if (prev_req && !bus.mem_ack) begin
            check_eq("hold_addr", bus.mem_addr, prev_addr);
            check_eq("hold_we", {31'h0, bus.mem_we}, {31'h0, prev_we});
            if (bus.mem_we) check_eq("hold_wdata", bus.mem_wdata, prev_wd);
          end
        end
        if (bus.resp_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("resp_unexpected", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check_eq("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
            check_eq("resp_rdata", bus.resp_rdata, e.rdata);
            check_eq("mem_req_cycles", req_cnt, e.req_cyc);
            check_eq("mem_we_cycles", we_cnt, e.we_cyc);
            check_eq("latency", cyc - e.acc + 1, e.lat);
          end
          req_cnt = 0;
          we_cnt  = 0;
        end
        prev_req  = bus.mem_req;
        prev_we   = bus.mem_we;
        prev_addr = bus.mem_addr;
        prev_wd   = bus.mem_wdata;
      end
    end
  end

  task automatic drive_accept(input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, output bit acc);
    bit ready_now;
    acc           = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_opcode = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      ready_now = bus.req_ready;
      @(posedge clk);
      #1;
      acc = ready_now;
    end
    bus.req_valid = 1'b0;
    if (!acc) check_eq("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                      input logic err, input logic [31:0] rd, input int rq, input int we,
                      input int lat);
    resp_t e;
    bit    acc;
    drive_accept(op, addr, wd, acc);
    if (!acc) return;
    e.err     = err;
    e.rdata   = rd;
    e.req_cyc = rq;
    e.we_cyc  = we;
    e.lat     = lat;
    e.acc     = cyc;
    exp_q.push_back(e);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #3;
    end
    if (exp_q.size() != 0) begin
      check_eq("resp_timeout", exp_q.size(), 32'h0);
      exp_q.delete();
    end
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
  endtask

  initial begin
    bit acc;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 6'h0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check_eq("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check_eq("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check_eq("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
    #2;
    rst_n = 1'b1;

    // Loads: op, addr, wdata, err, rdata, mem_req cycles, mem_we cycles, latency
    mem_model[32'h100] = 32'h80FF_1234;
    send(OpLb,  32'h103, 32'h0, 1'b0, 32'hFFFF_FF80, 1, 0, 2);
    send(OpLbu, 32'h103, 32'h0, 1'b0, 32'h0000_0080, 1, 0, 2);
    send(OpLb,  32'h100, 32'h0, 1'b0, 32'h0000_0034, 1, 0, 2);
    send(OpLb,  32'h102, 32'h0, 1'b0, 32'hFFFF_FFFF, 1, 0, 2);
    send(OpLbu, 32'h101, 32'h0, 1'b0, 32'h0000_0012, 1, 0, 2);
    mem_model[32'h100] = 32'h8001_0000;
    send(OpLh,  32'h102, 32'h0, 1'b0, 32'hFFFF_8001, 1, 0, 2);
    send(OpLhu, 32'h102, 32'h0, 1'b0, 32'h0000_8001, 1, 0, 2);
    mem_model[32'h104] = 32'hDEAD_BEEF;
    send(OpLw,  32'h104, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 0, 2);

    // Partial stores: read then merged write
    mem_model[32'h200] = 32'h1122_3344;
    expect_write(32'h200, 32'h1122_AB44);
    send(OpSb, 32'h201, 32'h0000_00AB, 1'b0, 32'h0, 2, 1, 3);
    mem_model[32'h200] = 32'h1122_3344;
    expect_write(32'h200, 32'hCAFE_3344);
    send(OpSh, 32'h202, 32'h0000_CAFE, 1'b0, 32'h0, 2, 1, 3);
    mem_model[32'h200] = 32'h1122_3344;
    expect_write(32'h200, 32'hEE22_3344);
    send(OpSb, 32'h203, 32'hFFFF_FFEE, 1'b0, 32'h0, 2, 1, 3);
    mem_model[32'h200] = 32'h1122_3344;
    expect_write(32'h200, 32'h1122_BEEF);
    send(OpSh, 32'h200, 32'h1234_BEEF, 1'b0, 32'h0, 2, 1, 3);

    // Word store with three memory wait cycles
    mem_waits = 3;
    expect_write(32'h300, 32'h1234_5678);
    send(OpSw, 32'h300, 32'h1234_5678, 1'b0, 32'h0, 4, 4, 5);
    mem_waits = 0;

    // Errors never touch memory
    send(OpLw,  32'h302, 32'h0, 1'b1, 32'h0, 0, 0, 1);
    send(OpSh,  32'h301, 32'hFFFF, 1'b1, 32'h0, 0, 0, 1);
    send(6'h00, 32'h300, 32'h0, 1'b1, 32'h0, 0, 0, 1);
    send(OpLhu, 32'h103, 32'h0, 1'b1, 32'h0, 0, 0, 1);

    // Timeout during the read of an sb: no write, error response
    never_ack = 1'b1;
    send(OpSb, 32'h201, 32'h0000_00AB, 1'b1, 32'h0, MaxWait, 0, MaxWait + 1);
    never_ack = 1'b0;

    // Reset in the middle of a read: no response for the aborted access
    never_ack = 1'b1;
    drive_accept(OpLb, 32'h400, 32'h0, acc);
    @(posedge clk);
    #3;
    check_eq("mid_mem_req_before", {31'h0, bus.mem_req}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check_eq("mid_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check_eq("mid_rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check_eq("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    never_ack = 1'b0;
    repeat (6) @(posedge clk);
    #3;

    // Recovery after reset
    send(OpLw, 32'h104, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 0, 2);

    check_eq("writes_outstanding", wr_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_load_store_controller.md
# mips_load_store_controller

Sequencing controller between the MIPS pipeline's memory stage and a single-port, word-wide data memory with a request/acknowledge handshake. Accepts one load or store at a time, issues aligned word accesses, performs read-modify-write for byte and halfword stores, and returns byte/halfword/word load data already lane-selected and extended. Misaligned, unsupported or timed-out accesses complete with an error response and no memory write.

## Interface
- MAX_WAIT, 16, maximum cycles the block holds mem_req for one access without mem_ack before it aborts (≥1).
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  pipeline presents an access.
- req_ready  output  1  block can accept; high only in IDLE.
- req_opcode  input  6  MIPS opcode: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for sb/sh.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data, valid with resp_valid on loads; 0 otherwise.
- resp_err  output  1  error flag, valid with resp_valid.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  32  word address, bits [1:0] always 00.
- mem_wdata  output  32  write word, valid while mem_req && mem_we.
- mem_ack  input  1  access complete; sampled only while mem_req high.
- mem_rdata  input  32  read word, valid with mem_ack on reads.

## Operation
- Little-endian lanes: byte n of a word is bits [8n+7:8n]; the lane is addr[1:0] for bytes and addr[1] for halfwords.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, capture opcode, addr, and wdata, then check:
  - unsupported opcode, or lw/sw with addr[1:0]≠00, or lh/lhu/sh with addr[0]=1 → RESP with resp_err=1.
  - loads, sb, sh → READ.
  - sw → WRITE with mem_wdata = req_wdata.
- READ: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. On mem_ack:
  - loads → RESP with extracted data: lw is the word; lh/lb sign-extend; lhu/lbu zero-extend.
  - sb/sh → WRITE with the merged word (mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0]); the merged word is registered.
- WRITE: mem_req=1, mem_we=1, same mem_addr. On mem_ack → RESP with resp_err=0.
- RESP: resp_valid=1 for exactly one cycle, with no backpressure, then IDLE.
- Wait counter: clears on entering READ/WRITE and increments each cycle mem_req is high without mem_ack. When it reaches MAX_WAIT:
  - drop mem_req and go to RESP with resp_err=1 and resp_rdata=0.
  - a timeout in READ of sb/sh performs no write.
- mem_ack outside READ/WRITE is ignored.

## Timing
- Reset values: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter 0.
- Reset asserted mid-access: at the next edge all outputs return to reset values, mem_req drops, and no response is produced for the aborted access.
- All outputs are registered or decoded from state only; there is no combinational path from mem_ack or req_valid to any output.
- mem_ack may arrive in the first cycle mem_req is high.
- Latency from accept edge (E0) to resp_valid, with zero-wait memory:
  - lw/lh/lb/sw: resp_valid in the 2nd cycle after E0.
  - sb/sh: resp_valid in the 3rd cycle after E0.
  - error: resp_valid in the 1st cycle after E0.
- Each memory wait cycle adds one cycle of latency.
- Back-to-back throughput: next accept in the cycle after RESP.
- mem_req stays continuously high, with stable mem_addr, mem_we and mem_wdata, from assertion until the cycle mem_ack is sampled or timeout.
- Timeout: mem_req is high for exactly MAX_WAIT cycles, then resp_valid follows in the next cycle.

## Test plan
- lb at addr 0x103 with memory word 0x80FF_1234 → one read at 0x100; resp_rdata=0xFFFF_FF80, resp_err=0. lbu at the same address → 0x0000_0080.
- lh at addr 0x102 with word 0x8001_0000 → resp_rdata=0xFFFF_8001. lhu → 0x0000_8001. lw at 0x104 with word 0xDEAD_BEEF → 0xDEAD_BEEF.
- sb at addr 0x201 with wdata=0x0000_00AB and old word 0x1122_3344 → a read, then a write at 0x200 of 0x1122_AB44. sh at 0x202 with wdata 0xCAFE → write 0xCAFE_3344.
- sw at 0x300 with memory inserting 3 wait cycles → mem_req high for 4 cycles with mem_we=1 and mem_wdata stable; resp_valid in the 5th cycle after accept.
- Errors with no mem_req at any point → resp_err=1 one cycle after accept:
  - lw at 0x302.
  - sh at 0x301.
  - opcode 6'b000000.
- Timeout and reset:
  - MAX_WAIT=4, memory never acks an sb → mem_req high for 4 cycles with mem_we=0 and no write; resp_err=1.
  - A separate case asserts rst_n=0 during READ → mem_req=0 and req_ready=1 after the edge, and no resp_valid.
